// File: rtl/multicycle_control.sv
// multicycle_control
//   Control unit for a multicycle RISC-V datapath. Every instruction walks
//   through IF, ID, EX, MEM and WB. LOAD and STORE hold MEM until data
//   memory reports dReady, or until WAIT_LIMIT wait cycles have passed. In
//   the timeout case the access is aborted and memErr is set.
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   IF    | instruction fetch
//   ID    | decode / register read
//   EX    | ALU operation; the next edge enters MEM and clears the wait counter
//   MEM   | data access; held for LOAD/STORE until dReady or timeout
//   WB    | write-back, PC update, instret increment
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   instr       current instruction (stable while PC is unchanged)
//   Zero        ALU zero flag from the datapath
//   dReady      data memory completed the current access
//   PCSrc       1 = branch target selected (WB only)
//   ALUSrc      1 = ALU operand 2 is the immediate
//   RegWrite    register file write strobe (WB only)
//   MemToReg    1 = write-back data comes from memory
//   ALUCtrl     ALU operation code
//   loadPC      PC update strobe (WB only)
//   MemRead     data memory read strobe (MEM, LOAD)
//   MemWrite    data memory write strobe (MEM, STORE)
//   memErr      sticky: a memory access timed out
//   instret     retired instruction count (wraps)
module multicycle_control #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        dReady,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        memErr,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    // The counter only has to reach WAIT_LIMIT-1: the cycle that would bring
    // it to WAIT_LIMIT is the exit cycle itself.
    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;

    state_t          state, state_next;
    logic [CW-1:0]   wait_cnt;
    logic            aborted;
    logic            mem_err_q;
    logic [31:0]     instret_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            alt;
    logic            is_load, is_store, is_branch, writes_rd;
    logic            is_mem;
    logic            timeout;
    logic            abort_now;

    logic            unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];

    // Decode, valid in every state. Unknown opcodes and funct3 = 011 under
    // OP/OP_IMM fall through to the defaults: ADD, register operand, no writes.
    always_comb begin
        ALUCtrl   = ALU_ADD;
        ALUSrc    = 1'b0;
        MemToReg  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                ALUSrc    = 1'b1;
                MemToReg  = 1'b1;
                is_load   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                ALUSrc   = 1'b1;
                is_store = 1'b1;
            end
            OPC_BRANCH: begin
                ALUCtrl   = ALU_SUB;
                is_branch = 1'b1;
            end
            OPC_OP_IMM: begin
                if (funct3 != 3'b011) begin
                    ALUSrc    = 1'b1;
                    writes_rd = 1'b1;
                    case (funct3)
                        3'b000:  ALUCtrl = ALU_ADD;
                        3'b001:  ALUCtrl = ALU_SLL;
                        3'b010:  ALUCtrl = ALU_SLT;
                        3'b100:  ALUCtrl = ALU_XOR;
                        3'b101:  ALUCtrl = alt ? ALU_SRA : ALU_SRL;
                        3'b110:  ALUCtrl = ALU_OR;
                        3'b111:  ALUCtrl = ALU_AND;
                        default: ALUCtrl = ALU_ADD;
                    endcase
                end
            end
            OPC_OP: begin
                if (funct3 != 3'b011) begin
                    writes_rd = 1'b1;
                    case (funct3)
                        3'b000:  ALUCtrl = alt ? ALU_SUB : ALU_ADD;
                        3'b001:  ALUCtrl = ALU_SLL;
                        3'b010:  ALUCtrl = ALU_SLT;
                        3'b100:  ALUCtrl = ALU_XOR;
                        3'b101:  ALUCtrl = alt ? ALU_SRA : ALU_SRL;
                        3'b110:  ALUCtrl = ALU_OR;
                        3'b111:  ALUCtrl = ALU_AND;
                        default: ALUCtrl = ALU_ADD;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign is_mem    = is_load | is_store;
    assign timeout   = (WAIT_LIMIT != 0) && (wait_cnt == LAST_WAIT);
    assign abort_now = (state == S_MEM) && is_mem && !dReady && timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IF;
            wait_cnt  <= '0;
            aborted   <= 1'b0;
            mem_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_EX) begin
                wait_cnt <= '0;
                aborted  <= 1'b0;
            end else if (state == S_MEM && is_mem && !dReady && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (abort_now) begin
                aborted   <= 1'b1;
                mem_err_q <= 1'b1;
            end
            if (state == S_WB)
                instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        PCSrc      = 1'b0;
        RegWrite   = 1'b0;
        loadPC     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        case (state)
            S_IF:  state_next = S_ID;
            S_ID:  state_next = S_EX;
            S_EX:  state_next = S_MEM;
            S_MEM: begin
                MemRead  = is_load;
                MemWrite = is_store;
                if (!is_mem || dReady || timeout)
                    state_next = S_WB;
            end
            S_WB: begin
                state_next = S_IF;
                loadPC     = 1'b1;
                RegWrite   = writes_rd & ~aborted;
                PCSrc      = is_branch & Zero;
            end
            default: state_next = S_IF;
        endcase
        // Reset can land mid-instruction; no write may escape in that cycle.
        if (rst) begin
            RegWrite = 1'b0;
            loadPC   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign memErr  = mem_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int WL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        dReady;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, memErr;
    logic [3:0]  ALUCtrl;
    logic [31:0] instret;

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dReady(dReady),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .memErr(memErr), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_instret;
    logic        m_memerr;

    typedef struct packed {
        logic [3:0] alu;
        logic       src;
        logic       m2r;
        logic       ld;
        logic       st;
        logic       br;
        logic       wr;
    } dec_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference decode straight from the opcode/funct3 tables.
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic [3:0] f3_alu [8];
        logic [2:0] f3;
        f3_alu = '{4'b0010, 4'b1001, 4'b0111, 4'b0010, 4'b1101, 4'b1000, 4'b0001, 4'b0000};
        f3 = i[14:12];
        d = '0;
        d.alu = 4'b0010;
        if (i[6:0] == 7'b0000011) begin
            d.ld = 1; d.src = 1; d.m2r = 1; d.wr = 1;
        end else if (i[6:0] == 7'b0100011) begin
            d.st = 1; d.src = 1;
        end else if (i[6:0] == 7'b1100011) begin
            d.br = 1; d.alu = 4'b0110;
        end else if ((i[6:0] == 7'b0010011 || i[6:0] == 7'b0110011) && f3 != 3'd3) begin
            d.wr  = 1;
            d.src = (i[6:0] == 7'b0010011);
            d.alu = f3_alu[f3];
            if (f3 == 3'd5 && i[30]) d.alu = 4'b1010;
            if (f3 == 3'd0 && i[30] && i[6:0] == 7'b0110011) d.alu = 4'b0110;
        end
        return d;
    endfunction

    // Runs one instruction starting in its IF cycle (called just after a
    // negedge). waits = MEM cycles with dReady low before it rises.
    // zmode: 0/1 force Zero, 2 random.
    task automatic run_instr(input logic [31:0] ins, input int waits, input int zmode);
        dec_t d;
        int   n_mem, cycles;
        bit   abort, mem_op, in_mem, in_wb;
        string ph;
        d      = ref_decode(ins);
        mem_op = d.ld | d.st;
        abort  = mem_op && (WL != 0) && (waits >= WL);
        n_mem  = !mem_op ? 1 : (abort ? WL : waits + 1);
        cycles = 4 + n_mem;
        for (int c = 0; c < cycles; c++) begin
            in_mem = (c >= 3) && (c < 3 + n_mem);
            in_wb  = (c == cycles - 1);
            ph     = in_wb ? "WB" : in_mem ? "MEM" : (c == 0) ? "IF" : (c == 1) ? "ID" : "EX";
            instr  = ins;
            Zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            if (in_mem && mem_op) dReady = ((c - 3) >= waits);
            else                  dReady = 1'($urandom);
            if (in_wb && abort) m_memerr = 1'b1;
            #1;
            chk({ph, " ALUCtrl"},  32'(ALUCtrl),  32'(d.alu));
            chk({ph, " ALUSrc"},   32'(ALUSrc),   32'(d.src));
            chk({ph, " MemToReg"}, 32'(MemToReg), 32'(d.m2r));
            chk({ph, " MemRead"},  32'(MemRead),  32'(in_mem & d.ld));
            chk({ph, " MemWrite"}, 32'(MemWrite), 32'(in_mem & d.st));
            chk({ph, " loadPC"},   32'(loadPC),   32'(in_wb));
            chk({ph, " RegWrite"}, 32'(RegWrite), 32'(in_wb & d.wr & !abort));
            chk({ph, " PCSrc"},    32'(PCSrc),    32'(in_wb & d.br & Zero));
            chk({ph, " memErr"},   32'(memErr),   32'(m_memerr));
            chk({ph, " instret"},  instret,       m_instret);
            if (in_wb) m_instret = m_instret + 32'd1;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [2:0] f3;
        int k;
        k  = $urandom_range(0, 5);
        f3 = 3'($urandom);
        case (k)
            0: opc = 7'b0110011;
            1: opc = 7'b0010011;
            2: opc = 7'b0000011;
            3: opc = 7'b0100011;
            4: opc = 7'b1100011;
            default: begin
                opc = 7'b1111111;
                for (int t = 0; t < 20; t++) begin
                    opc = 7'($urandom);
                    if (opc != 7'b0110011 && opc != 7'b0010011 && opc != 7'b0000011 &&
                        opc != 7'b0100011 && opc != 7'b1100011) break;
                    opc = 7'b1111111;
                end
            end
        endcase
        return {1'b0, 1'($urandom), 5'b0, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
    endfunction

    initial begin
        int w;
        rst = 1'b1; instr = 32'h0; Zero = 1'b0; dReady = 1'b0;
        m_instret = 0; m_memerr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset RegWrite", 32'(RegWrite), 0);
        chk("reset loadPC",   32'(loadPC),   0);
        chk("reset MemRead",  32'(MemRead),  0);
        chk("reset MemWrite", 32'(MemWrite), 0);
        chk("reset memErr",   32'(memErr),   0);
        chk("reset instret",  instret,       0);
        @(negedge clk);
        rst = 1'b0;

        run_instr(32'h002081B3, 0, 2);   // add
        run_instr(32'h0080A283, 3, 2);   // lw, 3 wait cycles
        run_instr(32'h0050A623, 0, 2);   // sw
        run_instr(32'h00208463, 0, 1);   // beq, taken
        run_instr(32'h00208463, 0, 0);   // beq, not taken
        run_instr(32'h4020D1B3, 0, 2);   // sra
        run_instr(32'h0020D193, 0, 2);   // srli
        run_instr(32'h0000007F, 0, 2);   // illegal opcode
        run_instr(32'h0020B1B3, 0, 2);   // OP funct3=011
        run_instr(32'h0020B193, 0, 2);   // OP_IMM funct3=011
        run_instr(32'h0080A283, 15, 2);  // lw, dReady on the limit cycle: success
        chk("memErr after boundary lw", 32'(memErr), 0);
        run_instr(32'h0080A283, 1000, 2); // lw, never ready: abort
        chk("memErr after abort", 32'(memErr), 1);
        run_instr(32'h002081B3, 0, 2);
        run_instr(32'h0050A623, 16, 2);  // sw abort path

        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(0, 9);
            if (w >= 7) w = (w == 7) ? WL - 1 : (w == 8) ? WL : WL + 5;
            else        w = $urandom_range(0, 3);
            run_instr(rand_instr(), w, 2);
        end

        // Reset in the middle of a store's MEM phase.
        instr = 32'h0050A623; dReady = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("sw MEM MemWrite before rst", 32'(MemWrite), 1);
        rst = 1'b1;
        #1;
        chk("rst mid-MEM MemWrite", 32'(MemWrite), 0);
        chk("rst mid-MEM loadPC",   32'(loadPC),   0);
        @(negedge clk); #1;
        chk("post-rst instret", instret,       0);
        chk("post-rst memErr",  32'(memErr),   0);
        chk("post-rst MemWrite", 32'(MemWrite), 0);
        m_instret = 0; m_memerr = 0;
        @(negedge clk);
        rst = 1'b0;
        run_instr(32'h002081B3, 0, 2);
        run_instr(32'h0080A283, 2, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
